rv32i_mem_stage: RTL and testbench

//  Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. Consumes the
//  EX/MEM-registered ALU result, store data and control signals. Runs a req/ready data-memory handshake
//  for loads and stores, aligns store data to byte lanes and sign/zero-extends load data.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/rv32i_lsu_align.sv | 63 ++++++
 rtl/rv32i_mem_stage.sv | 155 +++++++++++++++
 tb/tb_rv32i_mem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I memory stage: load/store size encodings and
// the data-memory handshake states.
package rv32i_pkg;

  localparam int FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Byte-lane steering for the memory stage: store enables/data replication,
// load extraction with sign/zero extension, and alignment checking.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic                access,
  input  logic                mem_write,
  input  logic [1:0]          offset,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [31:0]         store_data,
  input  logic [31:0]         rdata,
  output logic                misaligned,
  output logic [3:0]          be,
  output logic [31:0]         wdata,
  output logic [31:0]         load_data
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata >> {offset, 3'b000};

  // Alignment check, lane enables and store data replication
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = store_data;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        misaligned = access & offset[0];
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
      end
      F3_W: begin
        misaligned = access & (offset != 2'b00);
      end
      default: begin
        be = 4'b1111;
      end
    endcase
    if (!mem_write) begin
      be = 4'b1111;
    end else begin
      be = be;
    end
  end

  // Load extraction from the addressed lane
  always_comb begin
    load_data = shifted_s;
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_data = {24'h000000, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: data-memory req/ready handshake with bus timeout,
// and the MEM/WB pipeline register feeding write-back and forwarding.
module rv32i_mem_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         in_alu_result,
  input  logic [31:0]         in_store_data,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic                in_reg_write,
  input  logic [4:0]          in_rd,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ready,
  input  logic [31:0]         dmem_rdata,
  output logic                mem_stall,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                exc_misalign,
  output logic                exc_bus_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  mem_state_t  state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic        access_s, misaligned_s, req_s, stall_s, timeout_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_data_s;

  assign access_s = in_valid & (in_mem_read | in_mem_write);

  rv32i_lsu_align u_align (
    .access     (access_s),
    .mem_write  (in_mem_write),
    .offset     (in_alu_result[1:0]),
    .funct3     (in_funct3),
    .store_data (in_store_data),
    .rdata      (dmem_rdata),
    .misaligned (misaligned_s),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  // Handshake next state, request, stall and timeout decode
  always_comb begin
    state_nx_s = state_r;
    req_s      = 1'b0;
    stall_s    = 1'b0;
    timeout_s  = 1'b0;
    if (rst) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && !misaligned_s) begin
            req_s = 1'b1;
            if (!dmem_ready) begin
              stall_s    = 1'b1;
              state_nx_s = WAIT;
            end else begin
              state_nx_s = IDLE;
            end
          end else begin
            state_nx_s = IDLE;
          end
        end
        WAIT: begin
          req_s = 1'b1;
          if (dmem_ready) begin
            state_nx_s = IDLE;
          end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
            // abort releases the slot this cycle; request drops next cycle
            timeout_s  = 1'b1;
            state_nx_s = IDLE;
          end else begin
            stall_s    = 1'b1;
            state_nx_s = WAIT;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Wait-cycle counter, cleared whenever not waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT) && !dmem_ready) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= '0;
    end
  end

  // MEM/WB register: retire on non-stalled valid cycles, bubble otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_rd           <= 5'd0;
      wb_data         <= 32'h0000_0000;
      exc_misalign    <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end else if (in_valid && !stall_s) begin
      wb_valid        <= 1'b1;
      wb_reg_write    <= in_reg_write & ~in_mem_write & ~misaligned_s & ~timeout_s & (in_rd != 5'd0);
      wb_rd           <= in_rd;
      wb_data         <= in_mem_read ? load_data_s : in_alu_result;
      exc_misalign    <= misaligned_s;
      exc_bus_timeout <= timeout_s;
    end else begin
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_rd           <= 5'd0;
      wb_data         <= 32'h0000_0000;
      exc_misalign    <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end
  end

  assign dmem_req   = req_s;
  assign dmem_we    = in_mem_write;
  assign dmem_addr  = {in_alu_result[31:2], 2'b00};
  assign dmem_be    = be_s;
  assign dmem_wdata = wdata_s;
  assign mem_stall  = stall_s;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Self-checking bench for rv32i_mem_stage: directed table, reset-mid-wait
// sequence and randomized transactions against a rule-level model.
module tb_rv32i_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_alu_result, in_store_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read, in_mem_write, in_reg_write;
  logic [4:0]  in_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall, wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign, exc_bus_timeout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        mr, mw, rw;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] rdata;
    logic        x_req;
    int          x_end;
    logic [3:0]  x_be;
    logic [31:0] x_wd;
    logic        x_wbv, x_rw;
    logic [31:0] x_data;
    logic        x_mis, x_tmo;
  } vec_t;

  vec_t       tbl [15];
  logic [2:0] f3s [5];

  rv32i_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .exc_misalign(exc_misalign),
    .exc_bus_timeout(exc_bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Rule-level reference: derives expectations from the architectural definition
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    int     off = int'(v.alu[1:0]);
    int     size = (v.f3[1:0] == 2'd0) ? 1 : ((v.f3[1:0] == 2'd1) ? 2 : 4);
    logic   access = v.v & (v.mr | v.mw);
    logic [31:0] lane = v.rdata >> (off * 8);
    logic [31:0] mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (size * 8)) - 32'h1);
    logic [31:0] val  = lane & mask;
    r.x_mis = access & ((off % size) != 0);
    r.x_req = access & ~r.x_mis;
    r.x_tmo = r.x_req & (v.dly > TMO);
    r.x_end = !r.x_req ? 0 : ((v.dly <= TMO) ? v.dly : TMO);
    r.x_be  = 4'hF;
    r.x_wd  = 32'h0;
    if (v.mw) begin
      r.x_be = 4'(((1 << size) - 1) << off);
      r.x_wd = (size == 1) ? {4{v.sd[7:0]}} : ((size == 2) ? {2{v.sd[15:0]}} : v.sd);
    end
    if (size < 4 && !v.f3[2] && val[size*8-1]) val = val | ~mask;
    r.x_wbv  = v.v;
    r.x_rw   = v.v & v.rw & ~v.mw & ~r.x_mis & ~r.x_tmo & (v.rd != 5'd0);
    r.x_data = v.mr ? val : v.alu;
    return r;
  endfunction

  // Presents one instruction, runs the handshake to its end and checks MEM/WB
  task automatic run(input vec_t v);
    in_valid = v.v; in_alu_result = v.alu; in_store_data = v.sd; in_funct3 = v.f3;
    in_mem_read = v.mr; in_mem_write = v.mw; in_reg_write = v.rw; in_rd = v.rd;
    for (int c = 0; c <= v.x_end; c++) begin
      dmem_ready = (c == v.dly);
      dmem_rdata = (c == v.dly) ? v.rdata : $urandom;
      @(negedge clk);
      chk("dmem_req", 32'(dmem_req), 32'(v.x_req));
      chk("mem_stall", 32'(mem_stall), 32'(c < v.x_end));
      if (v.x_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(v.mw));
        chk("dmem_addr", dmem_addr, {v.alu[31:2], 2'b00});
        chk("dmem_be", 32'(dmem_be), 32'(v.x_be));
        if (v.mw) chk("dmem_wdata", dmem_wdata, v.x_wd);
      end
      @(posedge clk); #1;
      if (c < v.x_end) chk("wb_valid_bubble", 32'(wb_valid), 32'h0);
    end
    chk("wb_valid", 32'(wb_valid), 32'(v.x_wbv));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(v.x_rw));
    chk("exc_misalign", 32'(exc_misalign), 32'(v.x_mis));
    chk("exc_bus_timeout", 32'(exc_bus_timeout), 32'(v.x_tmo));
    if (v.x_rw) begin
      chk("wb_rd", 32'(wb_rd), 32'(v.rd));
      chk("wb_data", wb_data, v.x_data);
    end
    in_valid = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    chk("dmem_req_after", 32'(dmem_req), 32'h0);
    @(posedge clk); #1;
    chk("wb_valid_after", 32'(wb_valid), 32'h0);
    chk("exc_pulse_after", 32'({exc_misalign, exc_bus_timeout}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   kind;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    //           v     alu           sd            f3      mr    mw    rw    rd     dly rdata          req  end be    wdata         wbv   rw    data          mis   tmo
    tbl[0]  = '{1'b1, 32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd5,  0, 32'hDEAD_BEEF, 1'b1, 0, 4'hF, 32'h0,        1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0103, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 5'd6,  0, 32'h8012_3456, 1'b1, 0, 4'hF, 32'h0,        1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0103, 32'h0,        3'b100, 1'b1, 1'b0, 1'b1, 5'd6,  0, 32'h8012_3456, 1'b1, 0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0,  3, 32'h0,         1'b1, 3, 4'hC, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0101, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd8,  0, 32'h0,         1'b0, 0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0200, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd9,  7, 32'h0,         1'b1, 4, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_0055, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 5'd3,  0, 32'h0,         1'b0, 0, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0102, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 5'd10, 2, 32'h8001_1234, 1'b1, 2, 4'hF, 32'h0,        1'b1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0102, 32'h0,        3'b101, 1'b1, 1'b0, 1'b1, 5'd10, 1, 32'h8001_1234, 1'b1, 1, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0000_8001, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0301, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0,  1, 32'h0,         1'b1, 1, 4'h2, 32'hABAB_ABAB, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0010, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd0,  0, 32'h0000_0001, 1'b1, 0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0,  4, 32'h0,         1'b1, 4, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0203, 32'h0,        3'b001, 1'b0, 1'b1, 1'b0, 5'd0,  0, 32'h0,         1'b0, 0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd4,  0, 32'h0,         1'b0, 0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h0000_0000, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 5'd11, 2, 32'h0000_007F, 1'b1, 2, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0000_007F, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_alu_result = 32'h0; in_store_data = 32'h0;
    in_funct3 = 3'b000; in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
    in_rd = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid", 32'(wb_valid), 32'h0);
    chk("reset_wb_reg_write", 32'(wb_reg_write), 32'h0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_exc", 32'({exc_misalign, exc_bus_timeout}), 32'h0);
    chk("reset_dmem_req", 32'(dmem_req), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run(tbl[i]);

    // Reset while waiting on the bus: request abandoned, nothing written back
    in_valid = 1'b1; in_alu_result = 32'h0000_0080; in_funct3 = 3'b010;
    in_mem_read = 1'b1; in_mem_write = 1'b0; in_reg_write = 1'b1; in_rd = 5'd7;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_stall", 32'(mem_stall), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_hold_exc", 32'({exc_misalign, exc_bus_timeout}), 32'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    v = tbl[0];
    v.alu = 32'h0000_0084; v.dly = 1; v.rdata = 32'h1357_9BDF;
    run(model(v));

    for (int n = 0; n < 80; n++) begin
      kind    = $urandom_range(0, 2);
      v.v     = ($urandom_range(0, 7) != 0);
      v.alu   = $urandom;
      v.sd    = $urandom;
      v.f3    = (kind == 0) ? 3'($urandom) : ((kind == 2) ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)]);
      v.mr    = (kind == 1);
      v.mw    = (kind == 2);
      v.rw    = 1'($urandom);
      v.rd    = 5'($urandom);
      v.dly   = $urandom_range(0, 6);
      v.rdata = $urandom;
      run(model(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
